fxp_mul_seq: RTL and testbench

- Sequential shift-add fixed-point multiplier. It is the inverse companion of the team's combinational restoring divider.
- Operands and result use the same unsigned Q(W-FRAC).FRAC format as the divider. For the default of 8 bits this is 4.4.
- The result is p = floor(a*b / 2^FRAC). The full 2W-bit product is also exported.
- It sits beside the divider and sqrt datapath. It is used to square results and to check quotients (q*d ≈ n*2^FRAC).

---
 rtl/fxp_mul_seq.sv | 111 +++++++++++
 tb/tb_fxp_mul_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fxp_mul_seq.sv
// Sequential shift-add unsigned fixed-point multiplier; W+1 cycles start-to-done, fixed latency.
// start is ignored while busy; back-to-back start in the done cycle is accepted with no gap.
module fxp_mul_seq #(
   parameter int W    = 8,
   parameter int FRAC = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [W-1:0]   p,
   output logic [2*W-1:0] prod,
   output logic           ovf
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q;
   logic [2*W-1:0] mcand_q;
   logic [2*W-1:0] acc_q;
   logic [2*W-1:0] acc_d;
   logic [W-1:0]   mplier_q;
   logic [CW-1:0]  cnt_q;
   logic           busy_q;
   logic           done_q;
   logic [W-1:0]   p_q;
   logic [2*W-1:0] prod_q;
   logic           ovf_q;

   // mcand is pre-shifted to the current bit weight, so the sum never exceeds 2W bits
   always_comb begin
      acc_d = acc_q;
      if (mplier_q[0]) begin
         acc_d = acc_q + mcand_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         p_q      <= '0;
         prod_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  mcand_q  <= {{W{1'b0}}, a};
                  mplier_q <= b;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  prod_q  <= acc_d;
                  p_q     <= acc_d[FRAC+W-1:FRAC];
                  ovf_q   <= |acc_d[2*W-1:FRAC+W];
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  mcand_q  <= {{W{1'b0}}, a};
                  mplier_q <= b;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign p    = p_q;
   assign prod = prod_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_fxp_mul_seq.sv
// Randomized self-checking bench for fxp_mul_seq against a plain-arithmetic reference.
module tb_fxp_mul_seq;
   localparam int W    = 8;
   localparam int FRAC = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [W-1:0]   p;
   logic [2*W-1:0] prod;
   logic           ovf;

   int             n_tests = 0;
   int             n_fail  = 0;
   logic [W-1:0]   last_p;

   always #5 clk = ~clk;

   fxp_mul_seq #(.W(W), .FRAC(FRAC)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .p     (p),
      .prod  (prod),
      .ovf   (ovf)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One full operation; with disturb set, start is re-pulsed mid-run and operands toggle.
   task automatic run_op(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                         input bit disturb);
      int cyc;
      int nbusy;
      int prod_m;
      prod_m = int'(aa) * int'(bb);
      @(negedge clk);
      a = aa; b = bb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      nbusy = 0;
      while (!done && cyc < 40) begin
         if (busy) nbusy++;
         if (disturb) begin
            if (cyc == 3) begin
               start = 1'b1; a = 8'h11; b = 8'h22;
            end else begin
               start = 1'b0; a = ~a; b = ~b;
            end
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk({tag, " latency"}, 32'(cyc), 32'd9);
      chk({tag, " busy_cycles"}, 32'(nbusy), 32'd8);
      chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, " prod"}, 32'(prod), 32'(prod_m));
      chk({tag, " p"}, 32'(p), 32'((prod_m >> FRAC) % 256));
      chk({tag, " ovf"}, 32'(ovf), 32'(prod_m >= 4096));
      last_p = p;
      @(negedge clk);
      chk({tag, " done_pulse"}, 32'(done), 32'd0);
      chk({tag, " prod_held"}, 32'(prod), 32'(prod_m));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int ndone;
      int n;
      int d;
      int q;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst p",    32'(p),    32'd0);
      chk("rst prod", 32'(prod), 32'd0);
      chk("rst ovf",  32'(ovf),  32'd0);
      rst = 1'b0;

      run_op("2x3", 8'h20, 8'h30, 1'b0);
      run_op("1.5x2.5", 8'h18, 8'h28, 1'b0);
      run_op("zero", 8'h00, 8'hFF, 1'b0);
      run_op("lsb", 8'h01, 8'h01, 1'b0);
      run_op("max", 8'hFF, 8'hFF, 1'b0);
      run_op("4x4", 8'h40, 8'h40, 1'b0);

      run_op("ignored_start", 8'h20, 8'h30, 1'b1);
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("ignored_start extra_done", 32'(ndone), 32'd0);
      chk("ignored_start idle", 32'(busy), 32'd0);

      @(negedge clk);
      a = 8'h20; b = 8'h30; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("b2b first p", 32'(p), 32'h60);
      a = 8'h30; b = 8'h30; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b no_gap busy", 32'(busy), 32'd1);
      chk("b2b done_low", 32'(done), 32'd0);
      chk("b2b held p", 32'(p), 32'h60);
      cyc = 1;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("b2b spacing", 32'(cyc), 32'd9);
      chk("b2b p", 32'(p), 32'h90);
      chk("b2b prod", 32'(prod), 32'h0900);
      chk("b2b ovf", 32'(ovf), 32'd0);

      @(negedge clk);
      a = 8'h20; b = 8'h30; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      chk("abort p",    32'(p),    32'd0);
      chk("abort prod", 32'(prod), 32'd0);
      chk("abort ovf",  32'(ovf),  32'd0);
      ndone = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort no_done", 32'(ndone), 32'd0);
      run_op("after_abort", 8'h10, 8'h10, 1'b0);
      chk("after_abort p", 32'(last_p), 32'h10);

      for (int i = 0; i < 1000; i++) begin
         run_op("rnd", 8'($urandom), 8'($urandom), 1'b0);
      end

      // Divider reference: q = floor(n*2^FRAC/d), saturated to the W-bit range.
      for (int i = 0; i < 100; i++) begin
         n = int'($urandom_range(0, 255));
         d = int'($urandom_range(1, 255));
         q = (n << FRAC) / d;
         if (q > 255) q = 255;
         run_op("xchk", 8'(q), 8'(d), 1'b0);
         chk("xchk p_le_n", 32'(int'(last_p) <= n), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
